// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, FSM state encoding and operand-inversion helper shared by the ALU files
package alu_pkg;

    typedef enum logic [2:0] {
        OP_ADD  = 3'd0,
        OP_SUB  = 3'd1,
        OP_AND  = 3'd2,
        OP_OR   = 3'd3,
        OP_XOR  = 3'd4,
        OP_SLT  = 3'd5,
        OP_SLTU = 3'd6,
        OP_RSV  = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_e;

    // Ops that compute a - b as a + ~b + 1
    function automatic logic sub_like(input logic [2:0] op);
        return op == OP_SUB || op == OP_SLT || op == OP_SLTU;
    endfunction

endpackage

// File: rtl/chunk_adder.sv
// chunk_adder: CHUNK-bit ripple of full adders
//   a, b   : slice operands
//   cin    : carry into bit 0
//   sum    : slice sum
//   cout   : carry out of the top bit
//   c_msb  : carry into the top bit (for signed overflow)
module chunk_adder #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout,
    output logic             c_msb
);

    logic [CHUNK:0] c;

    always_comb begin
        c = '0;
        sum = '0;
        c[0] = cin;
        for (int i = 0; i < CHUNK; i++) begin
            sum[i] = a[i] ^ b[i] ^ c[i];
            c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
    end

    assign cout  = c[CHUNK];
    assign c_msb = c[CHUNK-1];

endmodule

// File: rtl/alu_seq_n.sv
// alu_seq_n: bit-serial (CHUNK bits per cycle) ALU with valid/ready handshakes
//   clock, reset           : clock, synchronous active-high reset
//   io_in_valid/ready      : request handshake; ready only in IDLE
//   io_in_a, io_in_b, io_in_op : operands and opcode (alu_pkg::op_e)
//   io_out_valid/ready     : result handshake; valid only in DONE
//   io_out_result, io_out_carry/overflow/zero/negative : registered result and flags
module alu_seq_n
    import alu_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             io_in_valid,
    output logic             io_in_ready,
    input  logic [WIDTH-1:0] io_in_a,
    input  logic [WIDTH-1:0] io_in_b,
    input  logic [2:0]       io_in_op,
    output logic             io_out_valid,
    input  logic             io_out_ready,
    output logic [WIDTH-1:0] io_out_result,
    output logic             io_out_carry,
    output logic             io_out_overflow,
    output logic             io_out_zero,
    output logic             io_out_negative
);

    localparam int STEPS = WIDTH / CHUNK;
    localparam int CW    = $clog2(STEPS + 1);

    if (CHUNK < 1 || WIDTH % CHUNK != 0 || WIDTH < 8 || WIDTH > 64) begin : g_bad_cfg
        $error("alu_seq_n: WIDTH must be 8..64 and a multiple of CHUNK");
    end

    state_e           state_q;
    op_e              op_q;
    logic [WIDTH-1:0] a_q, b_q, acc_q, acc_d, res_q, res_d;
    logic [CW-1:0]    cnt_q;
    logic             cin_q, carry_q, ovf_q, zero_q, neg_q;
    logic [CHUNK-1:0] sum, slice;
    logic             cout, c_msb, last, arith, ovf_d;

    chunk_adder #(.CHUNK(CHUNK)) u_add (
        .a    (a_q[CHUNK-1:0]),
        .b    (b_q[CHUNK-1:0]),
        .cin  (cin_q),
        .sum  (sum),
        .cout (cout),
        .c_msb(c_msb)
    );

    // Slices enter the accumulator at the top, so after STEPS shifts the LSB slice sits at bit 0.
    // On the last step acc_d is the full sum, and cout/c_msb belong to the MSB.
    always_comb begin
        slice = op_q == OP_AND ? a_q[CHUNK-1:0] & b_q[CHUNK-1:0] :
                op_q == OP_OR  ? a_q[CHUNK-1:0] | b_q[CHUNK-1:0] :
                op_q == OP_XOR ? a_q[CHUNK-1:0] ^ b_q[CHUNK-1:0] :
                op_q == OP_RSV ? '0 : sum;
        acc_d = (acc_q >> CHUNK) | (WIDTH'(slice) << (WIDTH - CHUNK));
        arith = op_q == OP_ADD || op_q == OP_SUB;
        ovf_d = c_msb ^ cout;
        res_d = op_q == OP_SLT  ? WIDTH'(acc_d[WIDTH-1] ^ ovf_d) :
                op_q == OP_SLTU ? WIDTH'(!cout) : acc_d;
        last  = cnt_q == CW'(STEPS - 1);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
            neg_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: if (io_in_valid) begin
                    a_q     <= io_in_a;
                    b_q     <= sub_like(io_in_op) ? ~io_in_b : io_in_b;
                    op_q    <= op_e'(io_in_op);
                    cin_q   <= sub_like(io_in_op);
                    cnt_q   <= '0;
                    acc_q   <= '0;
                    state_q <= S_BUSY;
                end
                S_BUSY: begin
                    a_q   <= a_q >> CHUNK;
                    b_q   <= b_q >> CHUNK;
                    cin_q <= cout;
                    acc_q <= acc_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (last) begin
                        res_q   <= res_d;
                        carry_q <= arith && cout;
                        ovf_q   <= arith && ovf_d;
                        zero_q  <= res_d == '0;
                        neg_q   <= res_d[WIDTH-1];
                        state_q <= S_DONE;
                    end
                end
                S_DONE: if (io_out_ready) state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign io_in_ready     = state_q == S_IDLE;
    assign io_out_valid    = state_q == S_DONE;
    assign io_out_result   = res_q;
    assign io_out_carry    = carry_q;
    assign io_out_overflow = ovf_q;
    assign io_out_zero     = zero_q;
    assign io_out_negative = neg_q;

endmodule

// File: tb/tb_alu_seq_n.sv
// tb_alu_seq_n: directed table, corner sequences and random ops against a behavioural ALU model
module tb_alu_seq_n;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    logic        in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0;
    logic [15:0] in_a = '0, in_b = '0, out_result;
    logic [2:0]  in_op = '0;
    logic        out_c, out_v, out_z, out_n;

    logic        e_valid = 1'b0, e_ready, e_out_valid, e_out_ready = 1'b0;
    logic [7:0]  e_a = '0, e_b = '0, e_result;
    logic [2:0]  e_op = '0;
    logic        e_c, e_v, e_z, e_n;

    alu_seq_n #(.WIDTH(16), .CHUNK(4)) dut (
        .clock(clock), .reset(reset),
        .io_in_valid(in_valid), .io_in_ready(in_ready),
        .io_in_a(in_a), .io_in_b(in_b), .io_in_op(in_op),
        .io_out_valid(out_valid), .io_out_ready(out_ready),
        .io_out_result(out_result), .io_out_carry(out_c),
        .io_out_overflow(out_v), .io_out_zero(out_z), .io_out_negative(out_n)
    );

    alu_seq_n #(.WIDTH(8), .CHUNK(8)) dut8 (
        .clock(clock), .reset(reset),
        .io_in_valid(e_valid), .io_in_ready(e_ready),
        .io_in_a(e_a), .io_in_b(e_b), .io_in_op(e_op),
        .io_out_valid(e_out_valid), .io_out_ready(e_out_ready),
        .io_out_result(e_result), .io_out_carry(e_c),
        .io_out_overflow(e_v), .io_out_zero(e_z), .io_out_negative(e_n)
    );

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [2:0]  op;
        logic [15:0] res;
        logic [3:0]  f;
        string       name;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Reference ALU from the arithmetic definitions; flags packed as {carry, ovf, zero, neg}
    function automatic void model(input int w, input logic [63:0] ai, input logic [63:0] bi,
                                  input logic [2:0] op, output logic [63:0] r, output logic [3:0] f);
        logic [64:0] s;
        logic [63:0] m, a, b;
        logic signed [63:0] sa, sb;
        logic c, v;
        m = (w == 64) ? '1 : (64'd1 << w) - 64'd1;
        a = ai & m;
        b = bi & m;
        sa = $signed(a << (64 - w)) >>> (64 - w);
        sb = $signed(b << (64 - w)) >>> (64 - w);
        c = 1'b0;
        v = 1'b0;
        r = '0;
        case (op)
            3'd0: begin
                s = a + b;
                r = s[63:0] & m;
                c = s[w];
                v = (a[w-1] == b[w-1]) && (r[w-1] != a[w-1]);
            end
            3'd1: begin
                r = (a - b) & m;
                c = a >= b;
                v = (a[w-1] != b[w-1]) && (r[w-1] != a[w-1]);
            end
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = a ^ b;
            3'd5: r = {63'd0, sa < sb};
            3'd6: r = {63'd0, a < b};
            default: r = '0;
        endcase
        f = {c, v, r == 0, r[w-1]};
    endfunction

    // One full transaction on the 16-bit DUT; junk with valid=1 is driven while busy to prove it is ignored
    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic [2:0] op, input int hold,
                          output logic [15:0] r, output logic [3:0] f, output int lat);
        chk("idle_ready", in_ready, 1);
        in_a = a; in_b = b; in_op = op; in_valid = 1'b1;
        @(posedge clock); #1;
        in_a = 16'($urandom); in_b = 16'($urandom); in_op = 3'($urandom);
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(posedge clock); #1;
            lat++;
        end
        if (!out_valid) chk("out_valid_timeout", out_valid, 1);
        r = out_result;
        f = {out_c, out_v, out_z, out_n};
        for (int h = 0; h < hold; h++) begin
            @(posedge clock); #1;
            chk("hold_result", out_result, r);
            chk("hold_flags", {out_c, out_v, out_z, out_n}, f);
            chk("hold_handshake", {in_ready, out_valid}, 2'b01);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clock); #1;
        out_ready = 1'b0;
        chk("back_to_idle", {in_ready, out_valid}, 2'b10);
    endtask

    task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                        output logic [7:0] r, output logic [3:0] f, output int lat);
        e_a = a; e_b = b; e_op = op; e_valid = 1'b1;
        @(posedge clock); #1;
        e_valid = 1'b0;
        lat = 1;
        while (!e_out_valid && lat < 20) begin
            @(posedge clock); #1;
            lat++;
        end
        chk("w8_valid", e_out_valid, 1);
        r = e_result;
        f = {e_c, e_v, e_z, e_n};
        e_out_ready = 1'b1;
        @(posedge clock); #1;
        e_out_ready = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] r, ra, rb;
        logic [7:0]  r8, a8, b8;
        logic [3:0]  f;
        logic [63:0] mr;
        logic [3:0]  mf;
        logic [2:0]  op;
        logic [15:0] corner[5];
        int lat, first, second;
        bit seen;

        vecs.push_back('{16'h7FFF, 16'h0001, 3'd0, 16'h8000, 4'b0101, "add_ovf"});
        vecs.push_back('{16'h0005, 16'h0005, 3'd1, 16'h0000, 4'b1010, "sub_eq"});
        vecs.push_back('{16'h0000, 16'h0001, 3'd1, 16'hFFFF, 4'b0001, "sub_borrow"});
        vecs.push_back('{16'hFFFF, 16'h0001, 3'd5, 16'h0001, 4'b0000, "slt_neg"});
        vecs.push_back('{16'hFFFF, 16'h0001, 3'd6, 16'h0000, 4'b0010, "sltu_big"});
        vecs.push_back('{16'hF0F0, 16'h0FF0, 3'd2, 16'h00F0, 4'b0000, "and"});
        vecs.push_back('{16'hF0F0, 16'h0FF0, 3'd3, 16'hFFF0, 4'b0001, "or"});
        vecs.push_back('{16'hF0F0, 16'h0FF0, 3'd4, 16'hFF00, 4'b0001, "xor"});
        vecs.push_back('{16'h1234, 16'h5678, 3'd7, 16'h0000, 4'b0010, "reserved"});
        vecs.push_back('{16'hFFFF, 16'h0001, 3'd0, 16'h0000, 4'b1010, "add_wrap"});
        vecs.push_back('{16'h8000, 16'h0001, 3'd1, 16'h7FFF, 4'b1100, "sub_ovf"});
        vecs.push_back('{16'h8000, 16'h7FFF, 3'd5, 16'h0001, 4'b0000, "slt_min"});
        vecs.push_back('{16'h8000, 16'h7FFF, 3'd6, 16'h0000, 4'b0010, "sltu_min"});

        repeat (2) @(posedge clock);
        #1;
        chk("reset_outputs", {out_valid, out_result, out_c, out_v, out_z, out_n}, '0);
        chk("reset_ready", in_ready, 1);
        reset = 1'b0;
        @(posedge clock); #1;
        chk("ready_after_release", {in_ready, out_valid}, 2'b10);

        foreach (vecs[i]) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].op, (i == 0) ? 3 : 0, r, f, lat);
            chk({vecs[i].name, "_result"}, r, vecs[i].res);
            chk({vecs[i].name, "_flags"}, f, vecs[i].f);
            chk({vecs[i].name, "_latency"}, lat, 5);
        end

        // Back-to-back with valid and out_ready held high: one op every STEPS+2 cycles
        out_ready = 1'b1;
        in_valid = 1'b1; in_a = 16'd1; in_b = 16'd1; in_op = 3'd0;
        first = -1; second = -1;
        for (int c = 0; c < 20; c++) begin
            @(posedge clock); #1;
            if (out_valid) begin
                chk("b2b_result", out_result, 16'd2);
                if (first < 0) first = c;
                else if (second < 0) second = c;
            end
        end
        chk("b2b_period", second - first, 6);
        in_valid = 1'b0;
        for (int c = 0; c < 10 && !in_ready; c++) begin
            @(posedge clock); #1;
        end
        out_ready = 1'b0;
        chk("b2b_idle", in_ready, 1);

        // Reset on the second BUSY cycle abandons the op
        in_valid = 1'b1; in_a = 16'd5; in_b = 16'd6; in_op = 3'd0;
        @(posedge clock); #1;
        in_valid = 1'b0;
        @(posedge clock); #1;
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        chk("abort_ready", {in_ready, out_valid}, 2'b10);
        chk("abort_result", out_result, 16'd0);
        seen = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clock); #1;
            if (out_valid) seen = 1'b1;
        end
        chk("abort_no_valid", seen, 0);
        run_op(16'd1, 16'd2, 3'd0, 0, r, f, lat);
        chk("after_abort_add", r, 16'd3);
        chk("after_abort_latency", lat, 5);

        // Randomized ops, biased toward corner operands
        corner = '{16'h0000, 16'hFFFF, 16'h8000, 16'h7FFF, 16'h0001};
        for (int n = 0; n < 150; n++) begin
            ra = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : 16'($urandom);
            rb = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : 16'($urandom);
            op = 3'($urandom_range(0, 7));
            model(16, {48'd0, ra}, {48'd0, rb}, op, mr, mf);
            run_op(ra, rb, op, $urandom_range(0, 1), r, f, lat);
            chk("rand_result", r, mr[15:0]);
            chk("rand_flags", f, mf);
            chk("rand_latency", lat, 5);
        end

        // WIDTH=8, CHUNK=8: single step
        run8(8'hFF, 8'h01, 3'd0, r8, f, lat);
        chk("w8_add_result", r8, 8'h00);
        chk("w8_add_flags", f, 4'b1010);
        chk("w8_latency", lat, 2);
        for (int n = 0; n < 30; n++) begin
            a8 = 8'($urandom);
            b8 = 8'($urandom);
            op = 3'($urandom_range(0, 7));
            model(8, {56'd0, a8}, {56'd0, b8}, op, mr, mf);
            run8(a8, b8, op, r8, f, lat);
            chk("w8_rand_result", r8, mr[7:0]);
            chk("w8_rand_flags", f, mf);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_seq_n.md
ALU_SEQ_N -- requirements
Module: alu_seq_n

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16: operand/result width in bits; legal values are 8 to 64.
REQ-002 The block SHALL have parameter CHUNK, default 4: bits processed per cycle; WIDTH % CHUNK == 0 is required and an elaboration error is raised otherwise. STEPS = WIDTH/CHUNK.
REQ-003 clock  in  1  single clock; all state updates on the rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 io_in_valid  in  1  operation request valid.
REQ-006 io_in_ready  out  1  block can accept a request.
REQ-007 io_in_a  in  WIDTH  operand A.
REQ-008 io_in_b  in  WIDTH  operand B.
REQ-009 io_in_op  in  3  opcode: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT, 6 SLTU, 7 reserved.
REQ-010 io_out_valid  out  1  result valid.
REQ-011 io_out_ready  in  1  consumer accepts the result.
REQ-012 io_out_result  out  WIDTH  result.
REQ-013 io_out_carry, io_out_overflow, io_out_zero, io_out_negative  out  1 each  flags.

Function
REQ-014 FSM states SHALL be IDLE, BUSY and DONE. io_in_ready = (state==IDLE). io_out_valid = (state==DONE).
REQ-015 On an edge in IDLE with io_in_valid=1:
- a, op and b' are captured (b' = ~b for SUB/SLT/SLTU, else b).
- Carry-in is set to 1 for SUB/SLT/SLTU, else 0.
- Step counter is cleared and state goes to BUSY.
REQ-016 Each BUSY edge SHALL process one CHUNK slice, LSB slice first, and register slice result and carry.
- The edge processing slice STEPS-1 moves state to DONE.
- Latency from capture edge to io_out_valid high is STEPS+1 edges (5 for defaults).
REQ-017 Arithmetic SHALL be a single WIDTH-bit two's-complement add of a + b' + cin; no separate negation of b.
REQ-018 Carry flag:
- ADD: carry out of the MSB.
- SUB: carry out of the MSB, where 1 means no borrow.
- All other ops: 0.
REQ-019 Overflow flag: for ADD/SUB, carry-into-MSB XOR carry-out-of-MSB; 0 for all other ops.
REQ-020 Logic ops SHALL produce the bitwise AND/OR/XOR of a and b.
REQ-021 SLT SHALL return result = zero-extended (sum_msb XOR ovf) of a−b. SLTU SHALL return result = zero-extended NOT carry of a−b.
REQ-022 Op 7 SHALL return result 0 with all flags 0 except zero=1.
REQ-023 zero = (result==0); negative = result[WIDTH-1]; both are valid for every op.
REQ-024 In DONE, result and flags SHALL stay stable while io_out_ready=0. On an edge with io_out_ready=1, state goes to IDLE.
REQ-025 No request is accepted in BUSY or DONE; io_in_valid is ignored there and inputs are don't-care.
REQ-026 With io_in_valid held high, back-to-back throughput SHALL be one op per STEPS+2 cycles.
REQ-027 The CHUNK==WIDTH configuration SHALL work with STEPS=1.

Reset
REQ-028 While reset=1 at an edge, the following SHALL be forced: state=IDLE, counter=0, io_out_result=0, all flags=0, io_out_valid=0.
- io_in_ready is 1 on the first cycle after reset is released.
REQ-029 Reset asserted in BUSY or DONE SHALL abandon the operation with no result delivered.

Structure
REQ-030 Shared package alu_pkg SHALL hold the opcode constants and the FSM state encoding.
REQ-031 The per-slice adder SHALL be a sub-module chunk_adder: a CHUNK-wide ripple of full adders with ports a, b, cin, sum, cout, and c_msb (carry into the top bit).
REQ-032 alu_seq_n SHALL instantiate exactly one chunk_adder, reused on every step. The operand shift registers, counter, FSM and flag logic SHALL live in alu_seq_n.

Verification (WIDTH=16, CHUNK=4 unless noted)
REQ-033 ADD 0x7FFF+0x0001 -> result 0x8000, ovf=1, neg=1, carry=0, zero=0; io_out_valid exactly 5 edges after capture.
REQ-034 SUB 0x0005−0x0005 -> result 0x0000, zero=1, carry=1, ovf=0. SUB 0x0000−0x0001 -> 0xFFFF, carry=0, neg=1.
REQ-035 SLT a=0xFFFF, b=0x0001 -> result 0x0001. SLTU with the same operands -> result 0x0000. AND 0xF0F0 with 0x0FF0 -> 0x00F0.
REQ-036 Hold io_out_ready=0 for 3 cycles in DONE -> outputs unchanged and io_in_ready=0 throughout; io_out_ready=1 -> IDLE on the next edge.
REQ-037 Assert reset on the 2nd BUSY cycle -> io_out_valid never rises, io_in_ready=1 next cycle; a new ADD 1+2 then returns 3.
REQ-038 With WIDTH=8, CHUNK=8: ADD 0xFF+0x01 -> result 0x00, carry=1, zero=1; latency 2 edges.
